// File: rtl/afifo_single_clk_if.sv
// Handshake bundle between the producer/consumer and afifo_single_clk.
// master: producer/consumer side, slave: the FIFO itself.
interface afifo_single_clk_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] wdata;
  logic             push;
  logic             pop;
  logic             wfull;
  logic             rempty;
  logic [WIDTH-1:0] rdata;

  modport master (
    output wdata, push, pop,
    input  wfull, rempty, rdata
  );

  modport slave (
    input  wdata, push, pop,
    output wfull, rempty, rdata
  );
endinterface

// File: rtl/afifo_single_clk.sv
// Single-clock FIFO with Gray-coded pointers and show-ahead read data.
// Pointer/flag structure matches the dual-clock FIFO so the block can later
// be split into two domains without touching the interface or flag logic.
// Optional build macro: AFIFO_PTR_SYNC_EN -- routes each cross-side Gray
// pointer through a 2-flop chain before flag comparison, reproducing the
// conservative flag timing of the dual-clock version.
module afifo_single_clk #(
  parameter int DEPTH = 16,
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  afifo_single_clk_if.slave bus
);

  localparam logic [N:0] PTR_ONE = {{N{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  logic [N:0] wr_bin;
  logic [N:0] rd_bin;
  logic [N:0] wr_bin_nxt;
  logic [N:0] rd_bin_nxt;
  logic [N:0] wr_gray;
  logic [N:0] rd_gray;
  logic [N:0] wr_gray_cmp;
  logic [N:0] rd_gray_cmp;
  logic       push_ok;
  logic       pop_ok;

  // Requests are qualified by the flags as they stand before the edge.
  assign push_ok    = bus.push & ~bus.wfull;
  assign pop_ok     = bus.pop  & ~bus.rempty;
  assign wr_bin_nxt = push_ok ? wr_bin + PTR_ONE : wr_bin;
  assign rd_bin_nxt = pop_ok  ? rd_bin + PTR_ONE : rd_bin;

  // Binary pointers and their registered Gray copies advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin  <= '0;
      rd_bin  <= '0;
      wr_gray <= '0;
      rd_gray <= '0;
    end else begin
      wr_bin  <= wr_bin_nxt;
      rd_bin  <= rd_bin_nxt;
      wr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
    end
  end

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_bin[N-1:0]] <= bus.wdata;
    end
  end

`ifdef AFIFO_PTR_SYNC_EN
  logic [N:0] wr_gray_s1;
  logic [N:0] rd_gray_s1;

  // Two-stage chains delay each opposite-side pointer as a CDC synchronizer would.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_gray_s1  <= '0;
      wr_gray_cmp <= '0;
      rd_gray_s1  <= '0;
      rd_gray_cmp <= '0;
    end else begin
      wr_gray_s1  <= wr_gray;
      wr_gray_cmp <= wr_gray_s1;
      rd_gray_s1  <= rd_gray;
      rd_gray_cmp <= rd_gray_s1;
    end
  end
`else
  assign wr_gray_cmp = wr_gray;
  assign rd_gray_cmp = rd_gray;
`endif

  // Full when the write pointer is exactly one lap ahead: Gray form inverts
  // the two MSBs of the read pointer.
  assign bus.rempty = (rd_gray == wr_gray_cmp);
  assign bus.wfull  = (wr_gray == {~rd_gray_cmp[N:N-1], rd_gray_cmp[N-2:0]});

  // Show-ahead head word; forced to zero while the FIFO reports empty.
  assign bus.rdata  = bus.rempty ? '0 : mem[rd_bin[N-1:0]];

endmodule

// File: tb/tb_afifo_single_clk.sv
// Self-checking bench for afifo_single_clk: directed sequences plus random
// streaming, compared against a queue-based occupancy model.
module tb_afifo_single_clk;

  localparam int DEPTH = 16;
  localparam int N     = 4;
  localparam int WIDTH = 8;
`ifdef AFIFO_PTR_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  afifo_single_clk_if #(.WIDTH(WIDTH)) bus ();

  afifo_single_clk #(.DEPTH(DEPTH), .N(N), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored words plus running push/pop counts, with a short
  // history so the opposite side can be viewed LAG edges late.
  logic [WIDTH-1:0] model_q[$];
  int               wr_h[$];
  int               rd_h[$];

  logic             pop_taken;
  logic [WIDTH-1:0] pop_word;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_empty();
    return rd_h[0] == wr_h[LAG];
  endfunction

  function automatic logic exp_full();
    return (wr_h[0] - rd_h[LAG]) == DEPTH;
  endfunction

  task automatic model_clear();
    model_q.delete();
    wr_h = '{0, 0, 0};
    rd_h = '{0, 0, 0};
  endtask

  // One clock cycle: drive, check outputs at negedge, advance the model at posedge.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic e_empty, e_full, push_acc;
    logic [WIDTH-1:0] e_rdata;
    bus.push  = p;
    bus.pop   = q;
    bus.wdata = d;
    @(negedge clk);
    e_empty = exp_empty();
    e_full  = exp_full();
    e_rdata = e_empty ? '0 : model_q[0];
    check_val("rempty", 32'(bus.rempty), 32'(e_empty));
    check_val("wfull",  32'(bus.wfull),  32'(e_full));
    check_val("rdata",  32'(bus.rdata),  32'(e_rdata));
    pop_word  = bus.rdata;
    pop_taken = q && !e_empty;
    push_acc  = p && !e_full;
    @(posedge clk);
    if (pop_taken) void'(model_q.pop_front());
    if (push_acc)  model_q.push_back(d);
    wr_h.push_front(wr_h[0] + (push_acc ? 1 : 0));
    rd_h.push_front(rd_h[0] + (pop_taken ? 1 : 0));
    wr_h = wr_h[0:2];
    rd_h = rd_h[0:2];
    #1;
  endtask

  // Reset with push/pop also asserted to confirm reset wins.
  task automatic do_reset();
    rst       = 1'b1;
    bus.push  = 1'b1;
    bus.pop   = 1'b1;
    bus.wdata = 8'hEE;
    @(posedge clk);
    model_clear();
    #1;
    rst      = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Pop until the DUT reports empty; returns how many words came out.
  task automatic drain(output int cnt);
    cnt = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (bus.rempty) break;
      step(1'b0, 1'b1, '0);
      if (pop_taken) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int pushed;
    int popped;
    int cycles;

    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.wdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    @(negedge clk);
    check_val("rst_rempty", 32'(bus.rempty), 32'd1);
    check_val("rst_wfull",  32'(bus.wfull),  32'd0);
    check_val("rst_rdata",  32'(bus.rdata),  32'd0);
    @(posedge clk); #1;

    // Basic ordering: 10..17 in, wait, 8 pops
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(10 + i));
    idle(5);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      check_val("order_pop", 32'(pop_word), 32'(10 + i));
    end
    idle(1);
    check_val("order_empty", 32'(bus.rempty), 32'd1);

    // Fill with 100..115, hold full, extra push ignored
    for (int i = 0; i < DEPTH; i++) begin
      check_val("fill_notfull", 32'(bus.wfull), 32'd0);
      step(1'b1, 1'b0, 8'(100 + i));
    end
    check_val("fill_full", 32'(bus.wfull), 32'd1);
    idle(5);
    step(1'b1, 1'b0, 8'hFF);
    check_val("full_hold", 32'(bus.wfull), 32'd1);

    // Drain 100..115, empty holds, extra pop harmless
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain_notempty", 32'(bus.rempty), 32'd0);
      step(1'b0, 1'b1, '0);
      check_val("drain_pop", 32'(pop_word), 32'(100 + i));
    end
    check_val("drain_empty", 32'(bus.rempty), 32'd1);
    idle(5);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 8'h77);
    idle(3);
    step(1'b0, 1'b1, '0);
    check_val("after_extra_pop", 32'(pop_word), 32'h77);
    idle(3);

    // Streaming across pointer wraps: 100 words 150..249
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(150 + i));
    pushed = 4;
    popped = 0;
    cycles = 0;
    while (popped < 100 && cycles < 2000) begin
      logic p, q;
      logic acc;
      p = (pushed < 100) && ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 3) != 0);
      acc = p && !exp_full();
      step(p, q, 8'(150 + pushed));
      if (acc) pushed++;
      if (pop_taken) begin
        check_val("stream_word", 32'(pop_word), 32'(150 + popped));
        popped++;
      end
      cycles++;
    end
    check_val("stream_count", 32'(popped), 32'd100);
    idle(3);
    check_val("stream_empty", 32'(bus.rempty), 32'd1);

    // Full with simultaneous push+pop: only the pop is taken
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(32 + i));
    step(1'b1, 1'b1, 8'hAB);
    check_val("full_pp_word", 32'(pop_word), 32'd32);
    idle(3);
    drain(cnt);
    check_val("full_pp_occ", 32'(cnt), 32'(DEPTH - 1));
    idle(3);

    // Empty with simultaneous push+pop: only the push is taken
    step(1'b1, 1'b1, 8'h33);
    idle(3);
    check_val("empty_pp_head", 32'(bus.rdata), 32'h33);
    drain(cnt);
    check_val("empty_pp_occ", 32'(cnt), 32'd1);
    idle(3);

    // Reset mid-operation discards stored words
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(200 + i));
    do_reset();
    @(negedge clk);
    check_val("mid_rst_rempty", 32'(bus.rempty), 32'd1);
    check_val("mid_rst_wfull",  32'(bus.wfull),  32'd0);
    check_val("mid_rst_rdata",  32'(bus.rdata),  32'd0);
    @(posedge clk); #1;
    step(1'b1, 1'b0, 8'h5A);
    cnt = 0;
    for (int i = 0; i < 8 && !pop_taken; i++) begin
      step(1'b0, 1'b1, '0);
      cnt++;
    end
    check_val("mid_rst_popped", 32'(pop_taken), 32'd1);
    check_val("mid_rst_word", 32'(pop_word), 32'h5A);
    check_val("mid_rst_lag", 32'(cnt), 32'(LAG + 1));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
